// File: rtl/l2cache_pkg.sv
// Shared types and default widths for the L2 refill path.
// Imported by the miss handler and its bench.
package l2cache_pkg;

    localparam int ADDR_W  = 4;
    localparam int TAG_W   = 20;
    localparam int LINE_W  = 128;
    localparam int LADDR_W = TAG_W + ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_FILL = 3'd4
    } miss_state_e;

endpackage

// File: rtl/l2cache_miss_handler.sv
// L2 refill controller: victim writeback, line fetch, array fill,
// and a one-cycle PLRU use pulse for the filled way.
module l2cache_miss_handler
    import l2cache_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int tag_width  = TAG_W,
    parameter int line_width = LINE_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [addr_width-1:0]         miss_index,
    input  logic [tag_width-1:0]          miss_tag,
    output logic [addr_width-1:0]         repl_addr,
    input  logic [1:0]                    way_sel,
    input  logic                          victim_valid,
    input  logic                          victim_dirty,
    input  logic [tag_width-1:0]          victim_tag,
    input  logic [line_width-1:0]         victim_data,
    output logic [3:0]                    use_pulse,
    output logic                          mem_wr_valid,
    input  logic                          mem_wr_ready,
    output logic [tag_width+addr_width-1:0] mem_wr_addr,
    output logic [line_width-1:0]         mem_wr_data,
    output logic                          mem_rd_valid,
    input  logic                          mem_rd_ready,
    output logic [tag_width+addr_width-1:0] mem_rd_addr,
    input  logic                          mem_resp_valid,
    input  logic [line_width-1:0]         mem_resp_data,
    output logic                          fill_we,
    output logic [1:0]                    fill_way,
    output logic [addr_width-1:0]         fill_index,
    output logic [tag_width-1:0]          fill_tag,
    output logic [line_width-1:0]         fill_data,
    output logic                          done
);

    miss_state_e           state_q, state_d;
    logic [addr_width-1:0] index_q, index_d;
    logic [tag_width-1:0]  tag_q, tag_d;
    logic [1:0]            way_q, way_d;
    logic [tag_width-1:0]  vtag_q, vtag_d;
    logic [line_width-1:0] vdata_q, vdata_d;
    logic [line_width-1:0] resp_q, resp_d;
    logic                  accept;
    logic                  resp_take;

    assign accept    = (state_q == ST_IDLE) && miss_valid;
    assign resp_take = (state_q == ST_WAIT) && mem_resp_valid;

    // State register; reset aborts any miss in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Miss context latches, including the victim way chosen at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            vtag_q  <= '0;
            vdata_q <= '0;
            resp_q  <= '0;
        end else begin
            index_q <= index_d;
            tag_q   <= tag_d;
            way_q   <= way_d;
            vtag_q  <= vtag_d;
            vdata_q <= vdata_d;
            resp_q  <= resp_d;
        end
    end

    // Capture the miss on accept and the fetched line in WAIT only.
    always_comb begin
        index_d = index_q;
        tag_d   = tag_q;
        way_d   = way_q;
        vtag_d  = vtag_q;
        vdata_d = vdata_q;
        resp_d  = resp_q;
        if (accept) begin
            index_d = miss_index;
            tag_d   = miss_tag;
            way_d   = way_sel;
            vtag_d  = victim_tag;
            vdata_d = victim_data;
        end
        if (resp_take) begin
            resp_d = mem_resp_data;
        end
    end

    // Next-state: writeback only for a valid dirty victim.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    state_d = (victim_valid && victim_dirty) ? ST_WB : ST_RD;
                end
            end
            ST_WB:   if (mem_wr_ready) state_d = ST_RD;
            ST_RD:   if (mem_rd_ready) state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) state_d = ST_FILL;
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake strobes and the single-cycle fill/use/done group.
    always_comb begin
        miss_ready   = 1'b0;
        mem_wr_valid = 1'b0;
        mem_rd_valid = 1'b0;
        fill_we      = 1'b0;
        done         = 1'b0;
        use_pulse    = 4'b0000;
        repl_addr    = index_q;
        unique case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                repl_addr  = miss_index;
            end
            ST_WB:   mem_wr_valid = 1'b1;
            ST_RD:   mem_rd_valid = 1'b1;
            ST_WAIT: ;
            ST_FILL: begin
                fill_we   = 1'b1;
                done      = 1'b1;
                use_pulse = 4'b0001 << way_q;
            end
            default: ;
        endcase
    end

    assign mem_wr_addr = {vtag_q, index_q};
    assign mem_wr_data = vdata_q;
    assign mem_rd_addr = {tag_q, index_q};
    assign fill_way    = way_q;
    assign fill_index  = index_q;
    assign fill_tag    = tag_q;
    assign fill_data   = resp_q;

endmodule

// File: tb/tb_l2cache_miss_handler.sv
// Bench for l2cache_miss_handler: vector table of misses, reactive
// memory model, and a negedge monitor checking against expectation queues.
module tb_l2cache_miss_handler;
    import l2cache_pkg::*;

    localparam int AW  = 4;
    localparam int TW  = 20;
    localparam int LW  = 128;
    localparam int LAW = TW + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_valid, miss_ready;
    logic [AW-1:0] miss_index, repl_addr, fill_index;
    logic [TW-1:0] miss_tag, victim_tag, fill_tag;
    logic [1:0]    way_sel, fill_way;
    logic          victim_valid, victim_dirty;
    logic [LW-1:0] victim_data, mem_wr_data, mem_resp_data, fill_data;
    logic [3:0]    use_pulse;
    logic          mem_wr_valid, mem_wr_ready;
    logic          mem_rd_valid, mem_rd_ready;
    logic [LAW-1:0] mem_wr_addr, mem_rd_addr;
    logic          mem_resp_valid, fill_we, done;

    l2cache_miss_handler dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_index(miss_index), .miss_tag(miss_tag),
        .repl_addr(repl_addr), .way_sel(way_sel),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .victim_tag(victim_tag), .victim_data(victim_data),
        .use_pulse(use_pulse),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_addr(mem_rd_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index),
        .fill_tag(fill_tag), .fill_data(fill_data), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] idx;
        logic [TW-1:0] tag;
        logic [1:0]    way;
        logic [1:0]    way_late;
        bit            vv;
        bit            vd;
        logic [TW-1:0] vtag;
        logic [LW-1:0] vdata;
        logic [LW-1:0] resp;
        int            wst;
        int            rdst;
        int            lat;
    } vec_t;

    typedef struct {
        logic [LAW-1:0] addr;
        logic [LW-1:0]  data;
    } wr_exp_t;

    typedef struct {
        logic [1:0]    way;
        logic [AW-1:0] idx;
        logic [TW-1:0] tag;
        logic [LW-1:0] data;
        logic [3:0]    use_v;
        int            lat;
        int            nwr;
    } fill_exp_t;

    wr_exp_t        exp_wr_q[$];
    logic [LAW-1:0] exp_rd_q[$];
    fill_exp_t      exp_fill_q[$];
    int             acc_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int            wr_stall = 0;
    int            rd_stall = 0;
    int            resp_lat = 1;
    logic [LW-1:0] resp_data = '0;
    int            spur_req = 0;
    bit            b2b_chk = 1'b0;
    int            last_done = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Memory model: stalls readies, returns one beat resp_lat cycles
    // after the fetch handshake, and can inject a stray response.
    initial begin : mem_model
        bit rd_hs;
        bit pend;
        int wc, rc, k, spur_seen;
        mem_wr_ready   = 1'b0;
        mem_rd_ready   = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        pend = 1'b0; wc = 0; rc = 0; k = 0; spur_seen = 0;
        forever begin
            @(negedge clk);
            rd_hs = mem_rd_valid && mem_rd_ready && !rst;
            if (rd_hs) begin
                pend = 1'b1;
                k = 0;
            end
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (pend) begin
                k++;
                if (k >= resp_lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = resp_data;
                    pend = 1'b0;
                end
            end
            if (spur_req != spur_seen) begin
                spur_seen = spur_req;
                if (!mem_resp_valid) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = {4{32'hBAD0BAD0}};
                end
            end
            if (mem_wr_valid && wc >= wr_stall) mem_wr_ready = 1'b1;
            else mem_wr_ready = 1'b0;
            wc = mem_wr_valid ? wc + 1 : 0;
            if (mem_rd_valid && rc >= rd_stall) mem_rd_ready = 1'b1;
            else mem_rd_ready = 1'b0;
            rc = mem_rd_valid ? rc + 1 : 0;
        end
    end

    // Monitor: handshake ordering, hold-stability and fill contents.
    bit             wr_pend = 1'b0, rd_pend = 1'b0;
    logic [LAW-1:0] wr_pa, rd_pa;
    logic [LW-1:0]  wr_pd;
    int             nwr = 0, nrd = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            wr_pend = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if (wr_pend) begin
                chk("wr_hold_valid", mem_wr_valid, 1);
                chk("wr_hold_addr", mem_wr_addr, wr_pa);
                chk("wr_hold_data", mem_wr_data, wr_pd);
            end
            if (rd_pend) begin
                chk("rd_hold_valid", mem_rd_valid, 1);
                chk("rd_hold_addr", mem_rd_addr, rd_pa);
            end
            wr_pend = mem_wr_valid && !mem_wr_ready;
            rd_pend = mem_rd_valid && !mem_rd_ready;
            wr_pa = mem_wr_addr;
            wr_pd = mem_wr_data;
            rd_pa = mem_rd_addr;
            if (mem_wr_valid && mem_rd_valid) chk("wr_rd_overlap", 1, 0);
            if (miss_valid && miss_ready) begin
                chk("accept_repl_addr", repl_addr, miss_index);
                acc_q.push_back(cyc);
                nwr = 0;
                nrd = 0;
                if (b2b_chk) begin
                    chk("b2b_accept_cycle", cyc, last_done + 1);
                    b2b_chk = 1'b0;
                end
            end
            if (mem_wr_valid && mem_wr_ready) begin
                wr_exp_t w;
                nwr++;
                if (exp_wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    w = exp_wr_q.pop_front();
                    chk("mem_wr_addr", mem_wr_addr, w.addr);
                    chk("mem_wr_data", mem_wr_data, w.data);
                end
            end
            if (mem_rd_valid && mem_rd_ready) begin
                nrd++;
                chk("wb_before_rd", exp_wr_q.size(), 0);
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("mem_rd_addr", mem_rd_addr, exp_rd_q.pop_front());
            end
            if (fill_we || done || use_pulse != 4'b0000) begin
                fill_exp_t f;
                if (exp_fill_q.size() == 0 || acc_q.size() == 0) begin
                    chk("fill_unexpected", 1, 0);
                end else begin
                    f = exp_fill_q.pop_front();
                    chk("fill_we", fill_we, 1);
                    chk("done", done, 1);
                    chk("use_pulse", use_pulse, f.use_v);
                    chk("fill_way", fill_way, f.way);
                    chk("fill_index", fill_index, f.idx);
                    chk("fill_tag", fill_tag, f.tag);
                    chk("fill_data", fill_data, f.data);
                    chk("fill_ready_low", miss_ready, 0);
                    chk("fill_latency", cyc - acc_q.pop_front(), f.lat);
                    chk("wr_handshakes", nwr, f.nwr);
                    chk("rd_handshakes", nrd, 1);
                end
                last_done = cyc;
            end
        end
    end

    vec_t vecs[5];

    task automatic push_exp(input vec_t v, input bit with_fill);
        wr_exp_t   w;
        fill_exp_t f;
        bit        dirty;
        dirty = v.vv && v.vd;
        if (dirty) begin
            w.addr = {v.vtag, v.idx};
            w.data = v.vdata;
            exp_wr_q.push_back(w);
        end
        exp_rd_q.push_back({v.tag, v.idx});
        if (with_fill) begin
            f.way   = v.way;
            f.idx   = v.idx;
            f.tag   = v.tag;
            f.data  = v.resp;
            f.use_v = 4'b0001 << v.way;
            f.lat   = (dirty ? 3 + v.wst : 2) + v.rdst + v.lat;
            f.nwr   = dirty ? 1 : 0;
            exp_fill_q.push_back(f);
        end
    endtask

    task automatic apply(input vec_t v);
        miss_index   = v.idx;
        miss_tag     = v.tag;
        way_sel      = v.way;
        victim_valid = v.vv;
        victim_dirty = v.vd;
        victim_tag   = v.vtag;
        victim_data  = v.vdata;
        wr_stall     = v.wst;
        rd_stall     = v.rdst;
        resp_lat     = v.lat;
        resp_data    = v.resp;
    endtask

    task automatic scramble(input vec_t v);
        miss_index   = ~v.idx;
        miss_tag     = ~v.tag;
        way_sel      = v.way_late;
        victim_valid = 1'b1;
        victim_dirty = 1'b1;
        victim_tag   = 20'hDEAD0;
        victim_data  = ~v.vdata;
    endtask

    task automatic wait_done(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    initial begin : driver
        vec_t a, b;
        int   nfill;
        miss_valid = 0; miss_index = 4'h9; miss_tag = '0; way_sel = '0;
        victim_valid = 0; victim_dirty = 0; victim_tag = '0; victim_data = '0;

        vecs[0] = '{4'h5, 20'h12345, 2'd2, 2'd1, 0, 0, 20'h0,
                    {4{32'h0BADF00D}}, {16{8'hA5}}, 0, 0, 3};
        vecs[1] = '{4'h3, 20'hABCDE, 2'd1, 2'd3, 1, 1, 20'h00001,
                    {4{32'h11112222}}, {16{8'h5A}}, 0, 0, 2};
        vecs[2] = '{4'hA, 20'h0F0F0, 2'd3, 2'd0, 1, 1, 20'h77777,
                    {4{32'hC0FFEE00}}, {4{32'h12345678}}, 4, 3, 1};
        vecs[3] = '{4'h0, 20'hFFFFF, 2'd0, 2'd3, 1, 0, 20'h55555,
                    {4{32'h33333333}}, {4{32'h89ABCDEF}}, 0, 0, 4};
        vecs[4] = '{4'hF, 20'h00042, 2'd1, 2'd2, 0, 1, 20'h66666,
                    {4{32'h44444444}}, {4{32'hFEDCBA98}}, 0, 1, 1};

        repeat (2) @(negedge clk);
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_repl_addr", repl_addr, 4'h9);
        chk("rst_wr_valid", mem_wr_valid, 0);
        chk("rst_rd_valid", mem_rd_valid, 0);
        chk("rst_fill_we", fill_we, 0);
        chk("rst_done", done, 0);
        chk("rst_use_pulse", use_pulse, 0);
        chk("rst_fill_data", fill_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            spur_req++;
            @(posedge clk);
            #1;
            apply(vecs[i]);
            miss_valid = 1'b1;
            push_exp(vecs[i], 1'b1);
            @(negedge clk);
            chk("vec_accept", miss_ready, 1);
            @(posedge clk);
            #1;
            miss_valid = 1'b0;
            scramble(vecs[i]);
            wait_done($sformatf("vec%0d", i));
        end

        a = '{4'h6, 20'h22222, 2'd1, 2'd0, 0, 0, 20'h0,
              '0, {4{32'hAAAA0001}}, 0, 0, 2};
        b = '{4'h7, 20'h33333, 2'd2, 2'd0, 0, 0, 20'h0,
              '0, {4{32'hBBBB0002}}, 0, 0, 1};
        @(posedge clk);
        #1;
        apply(a);
        miss_valid = 1'b1;
        push_exp(a, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        miss_index = b.idx; miss_tag = b.tag; way_sel = b.way;
        victim_valid = b.vv; victim_dirty = b.vd;
        push_exp(b, 1'b1);
        b2b_chk = 1'b1;
        wait_done("b2b_a");
        resp_lat  = b.lat;
        resp_data = b.resp;
        spur_req++;
        wait_done("b2b_b");
        chk("b2b_second_consumed", b2b_chk, 0);
        @(posedge clk);
        #1 miss_valid = 1'b0;

        a = '{4'h9, 20'h44444, 2'd3, 2'd1, 0, 0, 20'h0,
              '0, {4{32'hDDDD0003}}, 0, 0, 6};
        @(posedge clk);
        #1;
        apply(a);
        miss_valid = 1'b1;
        push_exp(a, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        miss_valid = 1'b0;
        scramble(a);
        miss_index = 4'hC;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_ready", miss_ready, 1);
        chk("rst_mid_repl", repl_addr, 4'hC);
        chk("rst_mid_rd_valid", mem_rd_valid, 0);
        chk("rst_mid_fill_we", fill_we, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_use", use_pulse, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nfill = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fill_we || done) nfill++;
        end
        chk("rst_no_fill", nfill, 0);
        chk("rst_idle_after", miss_ready, 1);

        repeat (2) @(negedge clk);
        chk("left_wr", exp_wr_q.size(), 0);
        chk("left_rd", exp_rd_q.size(), 0);
        chk("left_fill", exp_fill_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
